// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the iterative square-root unit.
// Widths derive from operand width XW and fractional result bits FRAC.
package sqrt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sqrt_state_t;

  function automatic int rw(input int xw, input int frac);
    return xw / 2 + frac;
  endfunction

  function automatic int ew(input int xw, input int frac);
    return xw + 2 * frac;
  endfunction

  function automatic bit xw_ok(input int xw);
    return (xw % 2 == 0) && (xw >= 4);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit-by-digit square-root iteration: brings down two operand bits and
// resolves one root bit. Purely combinational.
module sqrt_step #(
  parameter int RW = 16
) (
  input  logic [RW+1:0] q,
  input  logic [RW-1:0] r,
  input  logic [1:0]    bits,
  output logic [RW+1:0] q_next,
  output logic [RW-1:0] r_next
);

  logic [RW+1:0] t;
  logic [RW+1:0] d;
  logic          ge;

  // t and d never exceed RW+2 bits because the remainder stays <= 2*root.
  always_comb begin
    t      = (q << 2) | {{RW{1'b0}}, bits};
    d      = {r, 2'b01};
    ge     = (t >= d);
    q_next = ge ? (t - d) : t;
    r_next = {r[RW-2:0], ge};
  end

endmodule

// File: rtl/sqrt_iter.sv
// Sequential square root, one result bit per clock; RW cycles start-to-done.
// start is ignored while busy; abort cancels without touching sqrt/rem.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter  int XW   = 32,
  parameter  int FRAC = 0,
  localparam int RW   = rw(XW, FRAC),
  localparam int EW   = ew(XW, FRAC)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] xin,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] sqrt,
  output logic [RW:0]   rem
);

  localparam int KW = (RW > 2) ? $clog2(RW) : 1;

  if (!xw_ok(XW)) begin : g_bad_xw
    $error("sqrt_iter: XW must be even and >= 4");
  end

  sqrt_state_t   state;
  sqrt_state_t   state_next;
  logic [EW-1:0] x;
  logic [RW-1:0] r;
  logic [RW-1:0] r_next;
  logic [RW+1:0] q;
  logic [RW+1:0] q_next;
  logic [KW-1:0] k;

  sqrt_step #(.RW(RW)) u_step (
    .q      (q),
    .r      (r),
    .bits   (x[EW-1:EW-2]),
    .q_next (q_next),
    .r_next (r_next)
  );

  assign busy = (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (abort || (k == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      r     <= '0;
      q     <= '0;
      k     <= '0;
      done  <= 1'b0;
      sqrt  <= '0;
      rem   <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x <= EW'(xin) << (2 * FRAC);
            r <= '0;
            q <= '0;
            k <= KW'(RW - 1);
          end
        end
        RUN: begin
          // Abort takes priority even on the final step, so no result leaks out.
          if (!abort) begin
            x <= x << 2;
            r <= r_next;
            q <= q_next;
            k <= k - 1'b1;
            if (k == '0) begin
              sqrt <= r_next;
              rem  <= q_next[RW:0];
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sqrt_iter.md
# sqrt_iter

Parametrised sequential integer/fixed-point square-root unit: the next generation of the team's single-operand `sqrt` block, generalised in operand width and fractional precision, with a start/busy/done handshake, abort, and remainder output. One result bit is resolved per clock using the multiplier-free digit-by-digit (remainder) method. The unit sits as a coprocessor beside the datapath, which issues one operand at a time and collects the result on `done`.

## Interface
- `XW`, 32: operand width in bits; even, ≥ 4.
- `FRAC`, 0: fractional result bits, ≥ 0.
- Derived, not overridable:
  - `RW = XW/2 + FRAC`: result width.
  - `EW = XW + 2*FRAC`: extended operand width.
- `clock`  in  1: master clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `abort`  in  1: cancel the operation in progress.
- `xin`  in  XW: unsigned operand. Captured on the accepted `start` edge.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `sqrt`/`rem` update.
- `sqrt`  out  RW: floor(sqrt(xin·4^FRAC)), i.e. unsigned Q(XW/2).FRAC.
- `rem`  out  RW+1: xin·4^FRAC − sqrt².

## Operation
- States:
  - IDLE
  - RUN: bit counter `k` runs RW−1 down to 0.
- Registers: `x` (EW, operand shifted left by 2·FRAC), `r` (partial root, RW), `q` (partial remainder, RW+2), `k`.
- IDLE, `start`=1:
  - `x` ← {xin, 2·FRAC zeros}.
  - `r` ← 0, `q` ← 0, `k` ← RW−1.
  - Go to RUN.
- Each RUN cycle:
  - `t` = (`q`<<2) | next two MSBs of `x`; shift `x` left by 2.
  - `d` = (`r`<<2) | 1.
  - If `t` ≥ `d`: `q` ← `t`−`d`, `r` ← (`r`<<1)|1. Otherwise `q` ← `t`, `r` ← `r`<<1.
  - All arithmetic unsigned. `t`/`d` are RW+2 bits wide; no overflow is possible.
- RUN, `k`=0 (last step): write final `r`/`q` to `sqrt`/`rem`, pulse `done`, go to IDLE.
- `start` while busy is ignored. No queueing, no error flag.
- `abort`=1 in RUN: go to IDLE next edge. No `done`; `sqrt`/`rem` keep their previous values. `abort` in IDLE has no effect.
- `abort` and `start` together in IDLE: `start` wins, since `abort` has no effect in IDLE.
- `reset` overrides everything, including mid-operation. All registers and outputs go to 0, state goes to IDLE.
- Reset values: `busy`=0, `done`=0, `sqrt`=0, `rem`=0.
- `sqrt`/`rem` change only on the `done` cycle and are held until the next completion.

## Timing
- `start` sampled at edge E0. `busy`=1 from E0 through the cycle ending at E_RW.
- Bits resolved at edges E1..E_RW, MSB first.
- At E_RW: `sqrt`/`rem` valid and `done`=1 for exactly one cycle; `busy`=0 in the same cycle.
- Latency from start edge to result: RW cycles.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one result per RW+1 cycles.
- `abort` sampled at edge Ea: `busy`=0 after Ea; a `start` at Ea+1 is accepted.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `sqrt_pkg`:
  - State enum `sqrt_state_t` {IDLE, RUN}.
  - Width helper functions `rw(XW,FRAC)` and `ew(XW,FRAC)`.
  - Elaboration assertion that `XW` is even and ≥ 4.
- Sub-module `sqrt_step`: purely combinational single iteration.
  - Inputs: `q`, `r`, two operand bits.
  - Outputs: next `q`, next `r`.
  - Reused by the bench as the reference model.
- Top holds the FSM, counter, shift register and output registers.

## Test plan
- XW=32, FRAC=0, xin=1000000 → `sqrt`=1000, `rem`=0. `done` exactly 16 cycles after the start edge; `busy` high throughout.
- XW=32, FRAC=0, xin=0xFFFFFFFF → `sqrt`=0xFFFF, `rem`=0x1FFFE. xin=0 → `sqrt`=0, `rem`=0. xin=99 → `sqrt`=9, `rem`=18.
- XW=16, FRAC=4, xin=2 → `sqrt`=22 (0x016, i.e. 1.375), `rem`=28. Latency 12 cycles.
- `start` pulsed mid-RUN with a different xin → ignored; original result delivered. Back-to-back `start` in the `done` cycle → second result 17 cycles after the first start edge (XW=32).
- `abort` at cycle 5 of RUN → `busy` low next cycle, no `done`, `sqrt`/`rem` keep the prior result. `reset` at cycle 8 of RUN → all outputs 0, IDLE.
- Random 10k operands per configuration (XW ∈ {8,16,32}, FRAC ∈ {0,3}) → `sqrt`² ≤ x_ext < (`sqrt`+1)², and `rem` = x_ext − `sqrt`².
